rob_commit_buffer: RTL and testbench

Circular re-order buffer feeding the commit stage. Accepts in-order allocations from issue and out-of-order results from the write-back ports, then presents the oldest completed entries on `NR_COMMIT_PORTS` in-order commit ports. Pops exactly the entries the commit stage acknowledges. Sits between issue/execute and `commit_stage`; it is the producer side of the `commit_instr` / `commit_ack` interface.

---
 rtl/rob_commit_buffer.sv | 181 ++++++++++++++++++
 tb/tb_rob_commit_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_buffer.sv
// Circular re-order buffer: in-order allocate, out-of-order write-back, in-order commit.
// Optional macro ROB_WB_BYPASS_EN forwards same-cycle write-backs onto the commit ports.

package rob_commit_buffer_pkg;
  localparam int unsigned XLEN = 64;

  typedef struct packed {
    int unsigned TRANS_ID_BITS;
  } cfg_t;

  localparam cfg_t cva6_cfg_empty = '{TRANS_ID_BITS: 3};

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [7:0]      fu_op;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    exception_t      ex;
    logic            valid;
  } re_order_buffer_entry_t;
endpackage

module rob_commit_buffer
  import rob_commit_buffer_pkg::*;
#(
  parameter cfg_t        CVA6Cfg         = cva6_cfg_empty,
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned NR_WB_PORTS     = 4
) (
  input  logic                                                    clk_i,
  input  logic                                                    rst_ni,
  input  logic                                                    flush_i,
  input  logic                                                    alloc_valid_i,
  input  re_order_buffer_entry_t                                  alloc_entry_i,
  output logic                                                    alloc_ready_o,
  output logic [CVA6Cfg.TRANS_ID_BITS-1:0]                        alloc_trid_o,
  input  logic [NR_WB_PORTS-1:0]                                  wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][CVA6Cfg.TRANS_ID_BITS-1:0]       wb_trid_i,
  input  logic [NR_WB_PORTS-1:0][XLEN-1:0]                        wb_result_i,
  input  exception_t [NR_WB_PORTS-1:0]                            wb_ex_i,
  output re_order_buffer_entry_t [NR_COMMIT_PORTS-1:0]            commit_instr_o,
  output logic [NR_COMMIT_PORTS-1:0][CVA6Cfg.TRANS_ID_BITS-1:0]   commit_instr_trid_o,
  input  logic [NR_COMMIT_PORTS-1:0]                              commit_ack_i,
  output logic                                                    empty_o,
  output logic [CVA6Cfg.TRANS_ID_BITS:0]                          count_o
);

  localparam int unsigned TW = CVA6Cfg.TRANS_ID_BITS;
  localparam int unsigned CW = TW + 1;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] ISSUED = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]             state_q [NR_ENTRIES];
  re_order_buffer_entry_t entry_q [NR_ENTRIES];
  logic [TW-1:0]          head_q;
  logic [TW-1:0]          tail_q;
  logic [CW-1:0]          count_q;

  logic                   alloc_fire;
  re_order_buffer_entry_t alloc_clean;

  logic [NR_ENTRIES-1:0]  wb_hit;
  logic [NR_ENTRIES-1:0]  wb_absorb;
  logic [XLEN-1:0]        wb_res [NR_ENTRIES];
  exception_t             wb_exc [NR_ENTRIES];

  logic [TW-1:0]              cidx [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS-1:0] cvalid;
  logic [NR_COMMIT_PORTS-1:0] pop;
  logic [CW-1:0]              n_pop;

  assign alloc_ready_o = (count_q < CW'(NR_ENTRIES));
  assign alloc_trid_o  = tail_q;
  assign empty_o       = (count_q == '0);
  assign count_o       = count_q;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o && !flush_i;

  always_comb begin
    alloc_clean          = alloc_entry_i;
    alloc_clean.result   = '0;
    alloc_clean.ex.valid = 1'b0;
    alloc_clean.valid    = 1'b0;
  end

  // Per-entry write-back match; scanning ports high to low lets the lowest port win.
  always_comb begin
    for (int e = 0; e < NR_ENTRIES; e++) begin
      wb_hit[e] = 1'b0;
      wb_res[e] = '0;
      wb_exc[e] = '0;
      for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && (wb_trid_i[p] == TW'(e))) begin
          wb_hit[e] = 1'b1;
          wb_res[e] = wb_result_i[p];
          wb_exc[e] = wb_ex_i[p];
        end
      end
      wb_absorb[e] = wb_hit[e] && (state_q[e] == ISSUED);
    end
  end

  always_comb begin
    logic done;
    logic prev;
    prev = 1'b1;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      cidx[i]                = head_q + TW'(i);
      commit_instr_trid_o[i] = cidx[i];
      commit_instr_o[i]      = entry_q[cidx[i]];
      done                   = (state_q[cidx[i]] == DONE);
`ifdef ROB_WB_BYPASS_EN
      if (wb_absorb[cidx[i]]) begin
        done                     = 1'b1;
        commit_instr_o[i].result = wb_res[cidx[i]];
        commit_instr_o[i].ex     = wb_exc[cidx[i]];
      end
`endif
      cvalid[i]               = (count_q > CW'(i)) && done && prev;
      commit_instr_o[i].valid = cvalid[i];
      prev                    = cvalid[i];
    end
  end

  // A port only pops when every lower port pops too.
  always_comb begin
    logic prev;
    prev  = 1'b1;
    n_pop = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      pop[i] = commit_ack_i[i] && cvalid[i] && prev;
      prev   = pop[i];
      n_pop  = n_pop + CW'(pop[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < NR_ENTRIES; e++) state_q[e] <= FREE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      for (int e = 0; e < NR_ENTRIES; e++) state_q[e] <= FREE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int e = 0; e < NR_ENTRIES; e++) begin
        if (wb_absorb[e]) state_q[e] <= DONE;
      end
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (pop[i]) state_q[cidx[i]] <= FREE;
      end
      if (alloc_fire) state_q[tail_q] <= ISSUED;
      head_q  <= head_q + TW'(n_pop);
      tail_q  <= tail_q + TW'(alloc_fire);
      count_q <= count_q + CW'(alloc_fire) - n_pop;
    end
  end

  // Payload storage carries no reset; validity lives entirely in state_q.
  always_ff @(posedge clk_i) begin
    for (int e = 0; e < NR_ENTRIES; e++) begin
      if (wb_absorb[e] && !flush_i) begin
        entry_q[e].result <= wb_res[e];
        entry_q[e].ex     <= wb_exc[e];
      end
    end
    if (alloc_fire) entry_q[tail_q] <= alloc_clean;
  end

endmodule

// File: tb/tb_rob_commit_buffer.sv
// Directed bench for rob_commit_buffer with hand-computed expectations.
module tb_rob_commit_buffer;
  import rob_commit_buffer_pkg::*;

  logic                              clk;
  logic                              rst_n;
  logic                              flush;
  logic                              alloc_valid;
  re_order_buffer_entry_t            alloc_entry;
  logic                              alloc_ready;
  logic [2:0]                        alloc_trid;
  logic [3:0]                        wb_valid;
  logic [3:0][2:0]                   wb_trid;
  logic [3:0][63:0]                  wb_result;
  exception_t [3:0]                  wb_ex;
  re_order_buffer_entry_t [1:0]      commit_instr;
  logic [1:0][2:0]                   commit_trid;
  logic [1:0]                        ack;
  logic                              empty;
  logic [3:0]                        count;

  int checks = 0;
  int errors = 0;

  rob_commit_buffer dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .flush_i             (flush),
    .alloc_valid_i       (alloc_valid),
    .alloc_entry_i       (alloc_entry),
    .alloc_ready_o       (alloc_ready),
    .alloc_trid_o        (alloc_trid),
    .wb_valid_i          (wb_valid),
    .wb_trid_i           (wb_trid),
    .wb_result_i         (wb_result),
    .wb_ex_i             (wb_ex),
    .commit_instr_o      (commit_instr),
    .commit_instr_trid_o (commit_trid),
    .commit_ack_i        (ack),
    .empty_o             (empty),
    .count_o             (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_set(input int p, input logic [2:0] id, input logic [63:0] res,
                        input logic exv, input logic [63:0] cause);
    wb_valid[p]     = 1'b1;
    wb_trid[p]      = id;
    wb_result[p]    = res;
    wb_ex[p]        = '0;
    wb_ex[p].valid  = exv;
    wb_ex[p].cause  = cause;
  endtask

  task automatic wb_clear();
    wb_valid  = '0;
    wb_trid   = '0;
    wb_result = '0;
    wb_ex     = '0;
  endtask

  task automatic do_alloc(input logic [63:0] pc, input logic [2:0] exp_trid);
    chk("alloc_trid", 64'(alloc_trid), 64'(exp_trid));
    alloc_entry    = '0;
    alloc_entry.pc = pc;
    alloc_valid    = 1'b1;
    tick();
    alloc_valid    = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    alloc_valid = 1'b0;
    alloc_entry = '0;
    ack         = '0;
    wb_clear();

    #12;
    chk("rst_ready", 64'(alloc_ready), 64'd1);
    chk("rst_trid", 64'(alloc_trid), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_v0", 64'(commit_instr[0].valid), 64'd0);
    chk("rst_v1", 64'(commit_instr[1].valid), 64'd0);
    chk("rst_ctrid0", 64'(commit_trid[0]), 64'd0);
    chk("rst_ctrid1", 64'(commit_trid[1]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic out-of-order completion, in-order presentation
    do_alloc(64'h1000, 3'd0);
    do_alloc(64'h1004, 3'd1);
    do_alloc(64'h1008, 3'd2);
    chk("cnt3", 64'(count), 64'd3);
    wb_set(2, 3'd1, 64'h11, 1'b0, 64'd0);
    tick();
    wb_clear();
    chk("v0_before_id0", 64'(commit_instr[0].valid), 64'd0);
    wb_set(0, 3'd0, 64'h10, 1'b0, 64'd0);
    wb_set(1, 3'd0, 64'hBB, 1'b0, 64'd0);
    tick();
    wb_clear();
    chk("v0", 64'(commit_instr[0].valid), 64'd1);
    chk("ctrid0", 64'(commit_trid[0]), 64'd0);
    chk("res0_lowport", commit_instr[0].result, 64'h10);
    chk("pc0", commit_instr[0].pc, 64'h1000);
    chk("v1", 64'(commit_instr[1].valid), 64'd1);
    chk("res1", commit_instr[1].result, 64'h11);

    ack = 2'b10;
    tick();
    ack = 2'b00;
    chk("ack10_count", 64'(count), 64'd3);
    chk("ack10_head", 64'(commit_trid[0]), 64'd0);
    ack = 2'b11;
    tick();
    ack = 2'b00;
    chk("ack11_count", 64'(count), 64'd1);
    chk("ack11_head", 64'(commit_trid[0]), 64'd2);
    chk("id2_not_done", 64'(commit_instr[0].valid), 64'd0);

    // Exception write-back, then a duplicate that must be ignored
    wb_set(3, 3'd2, 64'h22, 1'b1, 64'd2);
    tick();
    wb_clear();
    chk("ex_v0", 64'(commit_instr[0].valid), 64'd1);
    chk("ex_valid", 64'(commit_instr[0].ex.valid), 64'd1);
    chk("ex_cause", commit_instr[0].ex.cause, 64'd2);
    wb_set(0, 3'd2, 64'h99, 1'b0, 64'd5);
    tick();
    wb_clear();
    chk("dup_cause", commit_instr[0].ex.cause, 64'd2);
    chk("dup_res", commit_instr[0].result, 64'h22);
    ack = 2'b01;
    tick();
    ack = 2'b00;
    chk("drain_empty", 64'(empty), 64'd1);

    // Fill with wrap (head=tail=3), drain two per cycle
    for (int k = 0; k < 8; k++) do_alloc(64'h2000 + 64'(k), 3'(3 + k));
    chk("full_ready", 64'(alloc_ready), 64'd0);
    chk("full_count", 64'(count), 64'd8);
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    chk("full_reject", 64'(count), 64'd8);
    for (int p = 0; p < 4; p++) wb_set(p, 3'(3 + p), 64'(p), 1'b0, 64'd0);
    tick();
    wb_clear();
    for (int p = 0; p < 4; p++) wb_set(p, 3'(7 + p), 64'(p + 4), 1'b0, 64'd0);
    tick();
    wb_clear();
    for (int k = 0; k < 4; k++) begin
      ack = 2'b11;
      tick();
      chk("drain_count", 64'(count), 64'(6 - 2 * k));
    end
    ack = 2'b00;
    chk("drain_empty2", 64'(empty), 64'd1);
    chk("wrap_trid", 64'(alloc_trid), 64'd3);

    // Full buffer: pop and allocate together; allocation rejected
    for (int k = 0; k < 8; k++) do_alloc(64'h3000 + 64'(k), 3'(3 + k));
    wb_set(0, 3'd3, 64'h33, 1'b0, 64'd0);
    tick();
    wb_clear();
    ack = 2'b01;
    alloc_valid = 1'b1;
    tick();
    ack = 2'b00;
    alloc_valid = 1'b0;
    chk("popalloc_count", 64'(count), 64'd7);
    chk("popalloc_ready", 64'(alloc_ready), 64'd1);
    do_alloc(64'h3100, 3'd3);
    chk("refill_count", 64'(count), 64'd8);

    // Bring occupancy to 5 entries (head=7)
    for (int p = 0; p < 3; p++) wb_set(p, 3'(4 + p), 64'(p), 1'b0, 64'd0);
    tick();
    wb_clear();
    ack = 2'b11;
    tick();
    ack = 2'b01;
    tick();
    ack = 2'b00;
    chk("pre_flush_count", 64'(count), 64'd5);
    chk("pre_flush_head", 64'(commit_trid[0]), 64'd7);

    // Flush with simultaneous allocation and write-back
    flush = 1'b1;
    alloc_valid = 1'b1;
    wb_set(0, 3'd7, 64'h77, 1'b0, 64'd0);
    #1;
`ifdef ROB_WB_BYPASS_EN
    chk("bypass_v0", 64'(commit_instr[0].valid), 64'd1);
    chk("bypass_res", commit_instr[0].result, 64'h77);
`else
    chk("nobypass_v0", 64'(commit_instr[0].valid), 64'd0);
`endif
    tick();
    flush = 1'b0;
    alloc_valid = 1'b0;
    wb_clear();
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_trid", 64'(alloc_trid), 64'd0);
    chk("flush_ctrid0", 64'(commit_trid[0]), 64'd0);
    chk("flush_v0", 64'(commit_instr[0].valid), 64'd0);

    do_alloc(64'h4000, 3'd0);
    wb_set(1, 3'd0, 64'h40, 1'b0, 64'd0);
    tick();
    wb_clear();
    chk("postflush_v0", 64'(commit_instr[0].valid), 64'd1);
    chk("postflush_res", commit_instr[0].result, 64'h40);
    chk("postflush_count", 64'(count), 64'd1);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_v0", 64'(commit_instr[0].valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
